cpu_trace_buffer: RTL and testbench



---
 rtl/cpu_trace_buffer.sv | 147 ++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Execute-stage trace capture. Records one packed record per executed
//   instruction into a circular buffer, keeps capturing while armed, stops
//   POST_TRIG records after a trigger and then allows oldest-first readout.
//
//   Optional feature macro: TRACE_FILTER_EN
//     defined   -> extra input filter_mask, record kept only if filter_mask[cap_op]
//     undefined -> every cap_valid record is kept
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   arm               clear buffer and start capturing
//   cap_valid/cap_*   record presented by the execute stage
//   trig              trigger event
//   rd_en             pop oldest record (only in DONE)
//   rd_valid/rd_data  popped record, one cycle after rd_en
//   count             records currently held
//   state, done       IDLE=0 ARMED=1 POST=2 DONE=3, done = (state==DONE)
//   filter_mask       opcode filter (TRACE_FILTER_EN only)
module cpu_trace_buffer #(
   parameter  int PC_W      = 8,
   parameter  int OP_W      = 4,
   parameter  int REG_W     = 4,
   parameter  int DATA_W    = 8,
   parameter  int DEPTH     = 16,
   parameter  int POST_TRIG = 4,
   localparam int REC_W     = PC_W + OP_W + REG_W + 3*DATA_W,
   localparam int CNT_W     = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              cap_valid,
   input  logic [PC_W-1:0]   cap_pc,
   input  logic [OP_W-1:0]   cap_op,
   input  logic [REG_W-1:0]  cap_dest,
   input  logic [DATA_W-1:0] cap_src1,
   input  logic [DATA_W-1:0] cap_src2,
   input  logic [DATA_W-1:0] cap_result,
   input  logic              trig,
   input  logic              rd_en,
   output logic              rd_valid,
   output logic [REC_W-1:0]  rd_data,
   output logic [CNT_W-1:0]  count,
   output logic [1:0]        state,
   output logic              done
`ifdef TRACE_FILTER_EN
   ,
   input  logic [2**OP_W-1:0] filter_mask
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           st;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] post_cnt;
   logic [REC_W-1:0] mem [DEPTH];

   logic             pass;
   logic             cap_en;
   logic             full;
   logic [REC_W-1:0] rec_in;

`ifdef TRACE_FILTER_EN
   assign pass = filter_mask[cap_op];
`else
   assign pass = 1'b1;
`endif

   assign rec_in = {cap_pc, cap_op, cap_dest, cap_src1, cap_src2, cap_result};
   assign full   = (count == CNT_W'(DEPTH));
   // arm takes priority: a record presented in the arming cycle is dropped
   assign cap_en = cap_valid && pass && !arm && (st == S_ARMED || st == S_POST);

   assign state = st;
   assign done  = (st == S_DONE);

   // Storage is not reset; only pointers/count define which slots are live.
   always_ff @(posedge clk) begin
      if (cap_en) mem[wr_ptr] <= rec_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= S_IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         post_cnt <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= 1'b0;
         if (arm) begin
            st       <= S_ARMED;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            post_cnt <= '0;
         end else begin
            // shared write-side bookkeeping; when full the oldest slot is
            // overwritten so the read pointer moves with the write pointer
            if (cap_en) begin
               wr_ptr <= wr_ptr + AW'(1);
               if (full) rd_ptr <= rd_ptr + AW'(1);
               else      count  <= count + CNT_W'(1);
            end
            case (st)
               S_IDLE: ;
               S_ARMED: begin
                  // a same-cycle capture is the trigger record itself and
                  // does not consume any of the post-trigger budget
                  if (trig) begin
                     post_cnt <= CNT_W'(POST_TRIG);
                     st       <= (POST_TRIG == 0) ? S_DONE : S_POST;
                  end
               end
               S_POST: begin
                  if (cap_en) begin
                     post_cnt <= post_cnt - CNT_W'(1);
                     if (post_cnt == CNT_W'(1)) st <= S_DONE;
                  end
               end
               S_DONE: begin
                  if (rd_en && count != '0) begin
                     rd_valid <= 1'b1;
                     rd_data  <= mem[rd_ptr];
                     rd_ptr   <= rd_ptr + AW'(1);
                     count    <= count - CNT_W'(1);
                  end
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: three DEPTH=4 instances sharing stimulus,
// POST_TRIG = 2, 1, 0. Expected records are queued as stimulus is driven
// and popped as the selected instance returns them.
module tb_cpu_trace_buffer;

   localparam int PC_W   = 8;
   localparam int OP_W   = 4;
   localparam int REG_W  = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int REC_W  = PC_W + OP_W + REG_W + 3*DATA_W;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst, arm, cap_valid, trig, rd_en;
   logic [PC_W-1:0]   cap_pc;
   logic [OP_W-1:0]   cap_op;
   logic [REG_W-1:0]  cap_dest;
   logic [DATA_W-1:0] cap_src1, cap_src2, cap_result;
`ifdef TRACE_FILTER_EN
   logic [2**OP_W-1:0] filter_mask;
`endif

   logic              rd_valid [3];
   logic [REC_W-1:0]  rd_data  [3];
   logic [CNT_W-1:0]  count    [3];
   logic [1:0]        state    [3];
   logic              done     [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      cpu_trace_buffer #(
         .PC_W(PC_W), .OP_W(OP_W), .REG_W(REG_W), .DATA_W(DATA_W),
         .DEPTH(DEPTH), .POST_TRIG(2-g)
      ) u_dut (
         .clk(clk), .rst(rst), .arm(arm), .cap_valid(cap_valid),
         .cap_pc(cap_pc), .cap_op(cap_op), .cap_dest(cap_dest),
         .cap_src1(cap_src1), .cap_src2(cap_src2), .cap_result(cap_result),
         .trig(trig), .rd_en(rd_en),
         .rd_valid(rd_valid[g]), .rd_data(rd_data[g]), .count(count[g]),
         .state(state[g]), .done(done[g])
`ifdef TRACE_FILTER_EN
         , .filter_mask(filter_mask)
`endif
      );
   end

   int total = 0;
   int bad   = 0;
   logic [REC_W-1:0] sb [$];
   logic [REC_W-1:0] last_rec;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] mk(input logic [7:0] pc, input logic [3:0] op);
      logic [7:0] s1, s2, r;
      s1 = pc * 8'd3;
      s2 = pc ^ 8'h5a;
      r  = s1 + s2;
      return {pc, op, pc[3:0] + 4'd1, s1, s2, r};
   endfunction

   // one cycle of stimulus: drive at negedge, return #1 after posedge
   task automatic step(input logic v, input logic [7:0] pc, input logic [3:0] op,
                       input logic t, input logic a, input logic r);
      logic [7:0] s1, s2;
      @(negedge clk);
      s1 = pc * 8'd3;
      s2 = pc ^ 8'h5a;
      cap_valid = v; cap_pc = pc; cap_op = op; cap_dest = pc[3:0] + 4'd1;
      cap_src1 = s1; cap_src2 = s2; cap_result = s1 + s2;
      trig = t; arm = a; rd_en = r;
      @(posedge clk); #1;
      cap_valid = 0; trig = 0; arm = 0; rd_en = 0;
   endtask

   // capture one record; push models the expected surviving history
   task automatic cap(input logic [7:0] pc, input logic [3:0] op, input logic t, input logic push);
      if (push) begin
         sb.push_back(mk(pc, op));
         if (sb.size() > DEPTH) void'(sb.pop_front());
      end
      step(1, pc, op, t, 0, 0);
   endtask

   task automatic do_arm();
      sb.delete();
      step(0, 0, 0, 0, 1, 0);
   endtask

   task automatic rd_chk(input int s, input string tag);
      logic [REC_W-1:0] e;
      step(0, 0, 0, 0, 0, 1);
      check({tag, ".vld"}, 64'(rd_valid[s]), 64'd1);
      if (sb.size() == 0) begin
         check({tag, ".sb_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, ".data"}, 64'(rd_data[s]), 64'(e));
         last_rec = e;
      end
   endtask

   initial begin
      rst = 1; arm = 0; cap_valid = 0; trig = 0; rd_en = 0;
      cap_pc = 0; cap_op = 0; cap_dest = 0; cap_src1 = 0; cap_src2 = 0; cap_result = 0;
`ifdef TRACE_FILTER_EN
      filter_mask = '1;
`endif
      #12;
      check("rst.state", 64'(state[0]), 64'd0);
      check("rst.count", 64'(count[0]), 64'd0);
      check("rst.vld",   64'(rd_valid[0]), 64'd0);
      check("rst.data",  64'(rd_data[0]), 64'd0);
      check("rst.done",  64'(done[0]), 64'd0);
      @(negedge clk); rst = 0;

      // rd_en in IDLE is ignored
      step(0, 0, 0, 0, 0, 1);
      check("idle.rd", 64'(rd_valid[0]), 64'd0);

      // basic: POST_TRIG=2 instance
      do_arm();
      check("basic.armed", 64'(state[0]), 64'd1);
      cap(8'd1, 4'd1, 0, 1);
      cap(8'd2, 4'd2, 1, 1);
      check("basic.post", 64'(state[0]), 64'd2);
      cap(8'd3, 4'd3, 0, 1);
      check("basic.post2", 64'(state[0]), 64'd2);
      cap(8'd4, 4'd4, 0, 1);
      check("basic.done_st", 64'(state[0]), 64'd3);
      check("basic.done",    64'(done[0]), 64'd1);
      check("basic.count",   64'(count[0]), 64'd4);
      for (int i = 0; i < 4; i++) rd_chk(0, "basic.rd");
      step(0, 0, 0, 0, 0, 1);
      check("basic.empty_vld",  64'(rd_valid[0]), 64'd0);
      check("basic.hold_data",  64'(rd_data[0]), 64'(last_rec));
      check("basic.empty_cnt",  64'(count[0]), 64'd0);
      check("basic.stay_done",  64'(state[0]), 64'd3);

      // wrap: POST_TRIG=1 instance, pc 1..6, trig on 5
      do_arm();
      for (int p = 1; p <= 6; p++) begin
         cap(8'(p), 4'(p), p == 5, 1);
         if (p == 5) check("wrap.post", 64'(state[1]), 64'd2);
      end
      check("wrap.done",  64'(state[1]), 64'd3);
      check("wrap.count", 64'(count[1]), 64'd4);
      for (int i = 0; i < 4; i++) rd_chk(1, "wrap.rd");

      // POST_TRIG=0 instance: trigger record with capture
      do_arm();
      cap(8'd6, 4'd6, 0, 1);
      cap(8'd7, 4'd7, 1, 1);
      check("pt0.done",  64'(state[2]), 64'd3);
      check("pt0.count", 64'(count[2]), 64'd2);
      rd_chk(2, "pt0.rd");
      rd_chk(2, "pt0.rd");
      check("pt0.last_pc7", 64'(last_rec[REC_W-1 -: PC_W]), 64'd7);
      // trigger without capture adds nothing; capture frozen in DONE
      do_arm();
      cap(8'd8, 4'd8, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      check("pt0b.done",  64'(state[2]), 64'd3);
      check("pt0b.count", 64'(count[2]), 64'd1);
      cap(8'd9, 4'd9, 0, 0);
      check("pt0b.frozen", 64'(count[2]), 64'd1);
      rd_chk(2, "pt0b.rd");

      // re-arm from DONE with count=2; same-cycle capture/read dropped
      do_arm();
      for (int p = 1; p <= 4; p++) cap(8'(p), 4'(p), p == 2, 1);
      rd_chk(0, "rearm.rd");
      rd_chk(0, "rearm.rd");
      check("rearm.cnt2", 64'(count[0]), 64'd2);
      sb.delete();
      step(1, 8'd20, 4'd0, 0, 1, 1);
      check("rearm.state", 64'(state[0]), 64'd1);
      check("rearm.count", 64'(count[0]), 64'd0);
      check("rearm.done",  64'(done[0]), 64'd0);
      check("rearm.vld",   64'(rd_valid[0]), 64'd0);
      step(0, 0, 0, 0, 0, 1);
      check("rearm.rd_ign", 64'(rd_valid[0]), 64'd0);
      cap(8'd5, 4'd5, 1, 1);
      cap(8'd6, 4'd6, 0, 1);
      cap(8'd7, 4'd7, 0, 1);
      check("rearm.done2", 64'(state[0]), 64'd3);
      check("rearm.cnt3",  64'(count[0]), 64'd3);
      rd_chk(0, "rearm.rd2");

`ifdef TRACE_FILTER_EN
      // filter: POST_TRIG=1 instance, only op 0 kept
      filter_mask = 16'h0001;
      do_arm();
      cap(8'd10, 4'd0, 1, 1);
      cap(8'd11, 4'd1, 0, 0);
      check("filt.post", 64'(state[1]), 64'd2);
      cap(8'd12, 4'd0, 0, 1);
      check("filt.done",  64'(state[1]), 64'd3);
      check("filt.count", 64'(count[1]), 64'd2);
      rd_chk(1, "filt.rd");
      check("filt.op0", 64'(last_rec[REC_W-PC_W-1 -: OP_W]), 64'd0);
      rd_chk(1, "filt.rd");
      check("filt.op1", 64'(last_rec[REC_W-PC_W-1 -: OP_W]), 64'd0);
      filter_mask = '1;
`endif

      // async reset mid-POST with count=3
      do_arm();
      cap(8'd1, 4'd1, 0, 0);
      cap(8'd2, 4'd2, 1, 0);
      cap(8'd3, 4'd3, 0, 0);
      check("arst.pre_state", 64'(state[0]), 64'd2);
      check("arst.pre_count", 64'(count[0]), 64'd3);
      #2 rst = 1;
      #1;
      check("arst.state", 64'(state[0]), 64'd0);
      check("arst.count", 64'(count[0]), 64'd0);
      check("arst.vld",   64'(rd_valid[0]), 64'd0);
      check("arst.done",  64'(done[0]), 64'd0);
      @(negedge clk); rst = 0;
      step(0, 0, 0, 0, 0, 0);
      check("arst.idle", 64'(state[0]), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
